alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, sequential successor to the team's combinational ALU circuits. It accepts one operation at a time over a valid/ready handshake and executes logic, arithmetic, comparison, shift/rotate and status-register operations in full-word or half-word mode. It keeps a persistent status register holding carry, zero and sign, and returns the result over a second valid/ready handshake. It sits between the decode stage and register-file writeback.

## Interface

Parameters:
- WORD_W, 20: full-word width; must be even and ≥ 4.
- HALF_W, WORD_W/2: half-word width (derived; not overridable).
- SH_W, $clog2(WORD_W+1): width of the shift-amount field.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: an operation is offered.
- in_ready, output, 1: the block can accept an operation.
- op, input, 4: opcode. 0 NOT, 1 AND, 2 OR, 3 XOR, 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 INC, 9 DEC, A ADD, B ADC, C SUB, D SBB, E CMP, F SRX.
- mode, input, 1: 1 selects full word; 0 selects half word.
- a, input, WORD_W: operand A.
- b, input, WORD_W: operand B.
- shamt, input, SH_W: shift/rotate distance.
- out_valid, output, 1: result and flags are valid.
- out_ready, input, 1: the consumer takes the result.
- result, output, WORD_W: operation result.
- sr, output, 3: status register, bit 2 = sign, bit 1 = zero, bit 0 = carry.

## Operation

- Active width L = WORD_W when mode = 1, else HALF_W. Operands are truncated to L bits. Result bits [WORD_W-1:L] are always 0.
- Flags, computed on the L-bit result:
  - zero = (result == 0).
  - sign = result[L-1].
  - carry is op-specific, as listed below.
- NOT, AND, OR, XOR: carry is unchanged.
- SHL: moves bits toward the MSB and fills with 0. carry = the last bit shifted out of position L-1.
- SHR: moves bits toward the LSB and fills with 0. carry = the last bit shifted out of position 0.
- ROL, ROR: rotate within L bits. carry = the last bit moved across the wrap boundary.
- Shift distance:
  - shamt = 0 gives result = a with carry unchanged.
  - shamt > L is clamped to L. SHL or SHR by L gives 0.
- INC, DEC, ADD, ADC: L-bit add. carry = carry-out of bit L-1. ADC adds sr[0] as carry-in.
- SUB, SBB: a − b (SBB also subtracts sr[0]). carry = borrow, i.e. the unsigned underflow.
- CMP: result = a. Flags are those of SUB, and the difference is discarded.
- SRX: sr ← sr ^ a[2:0]; result = a. Because SRX with sr = 0 loads sr directly, no separate load opcode exists.
- The status register updates exactly once per operation, at entry to DONE.

State machine:
- IDLE:
  - in_ready = 1.
  - On accept, capture op, mode, a, b and the clamped shamt.
  - Shift or rotate with shamt > 0 goes to EXEC. Everything else goes to DONE with the result computed in the same cycle.
- EXEC:
  - Perform one 1-bit step per cycle on an internal working register and decrement the count.
  - When the count reaches 1, the last step is done and the state goes to DONE.
- DONE:
  - out_valid = 1. result and sr are held stable.
  - When out_valid && out_ready, go to IDLE.
- in_ready is 0 in EXEC and DONE. Inputs change freely there and are ignored.

## Timing

- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - result = 0, sr = 3'b000, internal count = 0.
- Accept edge = cycle 0.
  - Non-shift ops, and shifts with shamt = 0: out_valid at cycle 1.
  - Shift or rotate with shamt = n: out_valid at cycle n+1 (after clamping).
- Back-pressure: DONE holds indefinitely. result, sr and out_valid must not change while out_ready = 0.
- Throughput: at most one operation per 2 cycles, because the handshake leaves DONE before IDLE accepts the next.
- Reset during EXEC or DONE: the operation is discarded, no output is ever produced for it, and sr returns to 0.
- sr is visible combinationally from its register. ADC and SBB issued after an operation has been consumed see that operation's carry.

## Structure

- Package alu_pkg holds:
  - the op_t enum of the 16 opcodes;
  - localparams for the sr bit indices (SR_C = 0, SR_Z = 1, SR_S = 2);
  - the state_t enum (IDLE, EXEC, DONE).
- Sub-module alu_step: purely combinational, one evaluation per call. Inputs: op, L-mask, working value, b, carry-in. Outputs: next value, carry, zero, sign. It performs the single-cycle ops and the 1-bit shift/rotate step.
- alu_seq holds the FSM, the operand and working registers, the counter and sr.

## Test plan

- ADD, mode 1, a = 0xFFFFF, b = 0x00001 → result 0x00000, sr = 3'b011, out_valid at cycle 1.
- ADD, mode 0, a = 0xFF3FF, b = 0x00001 → result 0x00000 with upper bits 0, carry = 1, zero = 1. Follow with ADC a = 0, b = 0 → result 0x00001.
- ROR, mode 1, a = 0x00001, shamt = 3 → out_valid at cycle 4, result 0x20000, sr = 3'b000. SHL with shamt = 25 is clamped to 20 → result 0, zero = 1, out_valid at cycle 21.
- CMP, a = 5, b = 7 → result 0x00005, carry = 1, zero = 0, sign = 1. Then SRX with a = 0x7 → sr = 3'b010.
- Back-pressure: hold out_ready = 0 for 10 cycles after a SUB → result and sr stable, in_ready = 0, and new in_valid pulses are ignored.
- Reset mid-EXEC (ROL, shamt = 10, rst asserted at cycle 5) → in_ready = 1, out_valid = 0, sr = 0, and no result is produced for that operation.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, status-register and FSM definitions for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOT = 4'h0, OP_AND = 4'h1, OP_OR  = 4'h2, OP_XOR = 4'h3,
        OP_SHL = 4'h4, OP_SHR = 4'h5, OP_ROL = 4'h6, OP_ROR = 4'h7,
        OP_INC = 4'h8, OP_DEC = 4'h9, OP_ADD = 4'hA, OP_ADC = 4'hB,
        OP_SUB = 4'hC, OP_SBB = 4'hD, OP_CMP = 4'hE, OP_SRX = 4'hF
    } op_t;

    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_S = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_shift(op_t o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) || (o == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_step.sv
// One combinational ALU evaluation: a full single-cycle op, or one 1-bit shift/rotate step.
// All values live in the low L bits selected by mask; bits above are kept at zero.
module alu_step
    import alu_pkg::*;
#(
    parameter int W = 20
) (
    input  op_t          op,
    input  logic [W-1:0] mask,
    input  logic [W-1:0] val,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] nxt,
    output logic         cout,
    output logic         zero,
    output logic         sign
);

    logic [W-1:0] msb;
    logic [W:0]   carry_pos;
    logic [W:0]   ext;
    logic [W-1:0] flag_val;
    logic         arith;
    logic         msb_bit;

    // msb marks bit L-1; carry_pos marks bit L of the widened sum/difference.
    assign msb       = mask ^ (mask >> 1);
    assign carry_pos = {mask, 1'b1} ^ {1'b0, mask};
    assign msb_bit   = |(val & msb);

    always_comb begin
        nxt   = val;
        cout  = cin;
        ext   = '0;
        arith = 1'b0;
        case (op)
            OP_NOT: nxt = ~val & mask;
            OP_AND: nxt = val & b;
            OP_OR:  nxt = val | b;
            OP_XOR: nxt = val ^ b;
            OP_SHL: begin
                nxt  = (val << 1) & mask;
                cout = msb_bit;
            end
            OP_SHR: begin
                nxt  = val >> 1;
                cout = val[0];
            end
            OP_ROL: begin
                nxt  = ((val << 1) & mask) | {{(W-1){1'b0}}, msb_bit};
                cout = msb_bit;
            end
            OP_ROR: begin
                nxt  = (val >> 1) | (val[0] ? msb : '0);
                cout = val[0];
            end
            // DEC adds the L-bit all-ones pattern, so carry is the add carry-out.
            OP_INC: begin ext = {1'b0, val} + (W+1)'(1);                       arith = 1'b1; end
            OP_DEC: begin ext = {1'b0, val} + {1'b0, mask};                    arith = 1'b1; end
            OP_ADD: begin ext = {1'b0, val} + {1'b0, b};                       arith = 1'b1; end
            OP_ADC: begin ext = {1'b0, val} + {1'b0, b} + {{W{1'b0}}, cin};    arith = 1'b1; end
            OP_SUB: begin ext = {1'b0, val} - {1'b0, b};                       arith = 1'b1; end
            OP_SBB: begin ext = {1'b0, val} - {1'b0, b} - {{W{1'b0}}, cin};    arith = 1'b1; end
            OP_CMP: begin ext = {1'b0, val} - {1'b0, b};                       arith = 1'b1; end
            OP_SRX: nxt = val;
            default: nxt = val;
        endcase
        if (arith) begin
            nxt  = ext[W-1:0] & mask;
            cout = |(ext & carry_pos);
        end
        flag_val = nxt;
        if (op == OP_CMP) begin
            nxt = val;
        end
        zero = (flag_val == '0);
        sign = |(flag_val & msb);
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one operation per valid/ready handshake, multi-cycle shifts, persistent sr.
// Handshakes: a transfer happens on a rising edge where valid && ready; in_ready only in IDLE, out_valid only in DONE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WORD_W = 20,
    localparam int HALF_W = WORD_W / 2,
    localparam int SH_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              mode,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [SH_W-1:0]   shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result,
    output logic [2:0]        sr
);

    state_t            state;
    op_t               op_r;
    logic [WORD_W-1:0] mask_r;
    logic [WORD_W-1:0] work;
    logic [SH_W-1:0]   cnt;

    op_t               op_in;
    logic [WORD_W-1:0] mask_in;
    logic [WORD_W-1:0] a_m;
    logic [WORD_W-1:0] b_m;
    logic [SH_W-1:0]   lim_in;
    logic [SH_W-1:0]   sh_c;

    op_t               s_op;
    logic [WORD_W-1:0] s_mask;
    logic [WORD_W-1:0] s_val;
    logic [WORD_W-1:0] s_b;
    logic [WORD_W-1:0] s_nxt;
    logic              s_cout;
    logic              s_zero;
    logic              s_sign;
    logic [2:0]        s_flags;

    assign op_in   = op_t'(op);
    assign mask_in = mode ? {WORD_W{1'b1}} : {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};
    assign a_m     = a & mask_in;
    assign b_m     = b & mask_in;
    assign lim_in  = mode ? SH_W'(WORD_W) : SH_W'(HALF_W);
    assign sh_c    = (shamt > lim_in) ? lim_in : shamt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        s_flags       = '0;
        s_flags[SR_C] = s_cout;
        s_flags[SR_Z] = s_zero;
        s_flags[SR_S] = s_sign;
    end

    // In IDLE a zero-distance shift is evaluated as OR with 0: result = a, carry kept.
    always_comb begin
        s_op   = op_in;
        s_mask = mask_in;
        s_val  = a_m;
        s_b    = b_m;
        if (state == EXEC) begin
            s_op   = op_r;
            s_mask = mask_r;
            s_val  = work;
            s_b    = '0;
        end else if (is_shift(op_in)) begin
            s_op = OP_OR;
            s_b  = '0;
        end
    end

    alu_step #(.W(WORD_W)) u_step (
        .op   (s_op),
        .mask (s_mask),
        .val  (s_val),
        .b    (s_b),
        .cin  (sr[SR_C]),
        .nxt  (s_nxt),
        .cout (s_cout),
        .zero (s_zero),
        .sign (s_sign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= OP_NOT;
            mask_r <= '0;
            work   <= '0;
            cnt    <= '0;
            result <= '0;
            sr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= op_in;
                        mask_r <= mask_in;
                        work   <= a_m;
                        cnt    <= sh_c;
                        if (is_shift(op_in) && (sh_c != '0)) begin
                            state <= EXEC;
                        end else begin
                            result <= s_nxt;
                            sr     <= (op_in == OP_SRX) ? (sr ^ a_m[2:0]) : s_flags;
                            state  <= DONE;
                        end
                    end
                end
                EXEC: begin
                    work <= s_nxt;
                    cnt  <= cnt - SH_W'(1);
                    if (cnt == SH_W'(1)) begin
                        result <= s_nxt;
                        sr     <= s_flags;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, random ops against a reference model,
// back-pressure and reset-during-execution behaviour.
module tb_alu_seq;

    localparam int W    = 20;
    localparam int SH_W = $clog2(W + 1);

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic            mode;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [SH_W-1:0] shamt;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    result;
    logic [2:0]      sr;

    alu_seq #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sr        (sr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [2:0]   exp_sr_q[$];
    int           exp_lat_q[$];

    logic [2:0]   model_sr;
    logic [W-1:0] got_res;
    logic [2:0]   got_sr;
    int           got_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole-distance shifts/rotates, plain arithmetic on 64-bit values.
    function automatic void model_op(input logic [3:0] o, input logic m, input logic [W-1:0] av,
                                     input logic [W-1:0] bv, input int s, input logic [2:0] sr_in,
                                     output logic [W-1:0] res, output logic [2:0] sr_out);
        int L, n;
        logic [63:0] mask, x, y, r, t, fv;
        logic c;
        L    = m ? W : W / 2;
        n    = (s > L) ? L : s;
        mask = (64'd1 << L) - 64'd1;
        x    = 64'(av) & mask;
        y    = 64'(bv) & mask;
        c    = sr_in[0];
        r    = x;
        fv   = 64'd0;
        case (o)
            4'h0: r = ~x & mask;
            4'h1: r = x & y;
            4'h2: r = x | y;
            4'h3: r = x ^ y;
            4'h4: if (n > 0) begin r = (x << n) & mask; c = x[L-n]; end
            4'h5: if (n > 0) begin r = x >> n; c = x[n-1]; end
            4'h6: if (n > 0) begin r = ((x << n) | (x >> (L-n))) & mask; c = r[0]; end
            4'h7: if (n > 0) begin r = ((x >> n) | (x << (L-n))) & mask; c = r[L-1]; end
            4'h8: begin t = x + 64'd1;            r = t & mask; c = t[L]; end
            4'h9: begin t = x + mask;             r = t & mask; c = t[L]; end
            4'hA: begin t = x + y;                r = t & mask; c = t[L]; end
            4'hB: begin t = x + y + 64'(c);       r = t & mask; c = t[L]; end
            4'hC: begin t = x - y;                r = t & mask; c = (x < y); end
            4'hD: begin t = x - y - 64'(c);       r = t & mask; c = (x < y + 64'(sr_in[0])); end
            4'hE: begin t = x - y;                r = x;        c = (x < y); fv = t & mask; end
            default: r = x;
        endcase
        if (o != 4'hE) fv = r;
        res = W'(r);
        if (o == 4'hF) sr_out = sr_in ^ x[2:0];
        else sr_out = {fv[L-1], (fv == 64'd0), c};
    endfunction

    // driver: offer one op, check latency/result/sr, optionally back-pressure for hold cycles
    task automatic run_op(input logic [3:0] o, input logic m, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [SH_W-1:0] s, input int hold);
        logic [W-1:0] er, hr;
        logic [2:0]   esr, hs;
        int L, n_eff, el, lat;
        L     = m ? W : W / 2;
        n_eff = (int'(s) > L) ? L : int'(s);
        model_op(o, m, av, bv, int'(s), model_sr, er, esr);
        model_sr = esr;
        el = ((o >= 4'h4) && (o <= 4'h7) && (n_eff > 0)) ? n_eff + 1 : 1;
        exp_q.push_back(er);
        exp_sr_q.push_back(esr);
        exp_lat_q.push_back(el);

        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        op = o; mode = m; a = av; b = bv; shamt = s; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 64) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 4'($urandom); a = W'($urandom); b = W'($urandom); shamt = SH_W'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("out_valid_seen", 32'(out_valid), 32'd1);

        hr = result;
        hs = sr;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 4'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_result", 32'(result), 32'(hr));
            check("hold_sr", 32'(sr), 32'(hs));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        // scoreboard
        check("result", 32'(result), 32'(exp_q.pop_front()));
        check("sr", 32'(sr), 32'(exp_sr_q.pop_front()));
        check("latency", 32'(lat), 32'(exp_lat_q.pop_front()));
        got_res = result;
        got_sr  = sr;
        got_lat = lat;

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int vcount;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; mode = 1'b1; a = '0; b = '0; shamt = '0;
        model_sr = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_sr", 32'(sr), 32'd0);
        rst = 1'b0;

        // directed cases
        run_op(4'hA, 1'b1, 20'hFFFFF, 20'h00001, '0, 0);
        check("add_full_res", 32'(got_res), 32'h0);
        check("add_full_sr", 32'(got_sr), 32'b011);
        check("add_full_lat", 32'(got_lat), 32'd1);

        run_op(4'hA, 1'b0, 20'hFF3FF, 20'h00001, '0, 0);
        check("add_half_res", 32'(got_res), 32'h0);
        check("add_half_sr", 32'(got_sr), 32'b011);
        run_op(4'hB, 1'b0, 20'h0, 20'h0, '0, 0);
        check("adc_res", 32'(got_res), 32'h1);

        run_op(4'h7, 1'b1, 20'h00001, 20'h0, SH_W'(3), 0);
        check("ror_res", 32'(got_res), 32'h20000);
        check("ror_sr", 32'(got_sr), 32'b000);
        check("ror_lat", 32'(got_lat), 32'd4);
        run_op(4'h4, 1'b1, 20'h00001, 20'h0, SH_W'(25), 0);
        check("shl_clamp_res", 32'(got_res), 32'h0);
        check("shl_clamp_zero", 32'(got_sr[1]), 32'd1);
        check("shl_clamp_lat", 32'(got_lat), 32'd21);

        run_op(4'hE, 1'b1, 20'h5, 20'h7, '0, 0);
        check("cmp_res", 32'(got_res), 32'h5);
        check("cmp_sr", 32'(got_sr), 32'b101);
        run_op(4'hF, 1'b1, 20'h7, 20'h0, '0, 0);
        check("srx_sr", 32'(got_sr), 32'b010);

        run_op(4'hC, 1'b1, 20'h12345, 20'h00345, '0, 10);
        check("sub_bp_res", 32'(got_res), 32'h12000);

        // random ops against the model
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                   SH_W'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        // reset in the middle of a long rotate
        run_op(4'hF, 1'b1, 20'h5, 20'h0, '0, 0);
        @(negedge clk);
        op = 4'h6; mode = 1'b1; a = 20'h12345; b = '0; shamt = SH_W'(10); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sr", 32'(sr), 32'd0);
        rst = 1'b0;
        model_sr = 3'b000;
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("midrst_no_output", 32'(vcount), 32'd0);
        run_op(4'hB, 1'b1, 20'h0, 20'h0, '0, 0);
        check("post_rst_adc", 32'(got_res), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
